// File: rtl/rom_boot_sequencer.sv
// Boot-time ROM download sequencer: buffers ioctl bytes, maps them to SDRAM
// pages/banks, issues writes on ce_ref slots and holds the CPU in reset until done.
module rom_boot_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int WAIT_LEVEL = 3
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  input  logic         ce_ref,
  input  logic         ioctl_download,
  input  logic         ioctl_wr,
  input  logic [24:0]  ioctl_addr,
  input  logic [7:0]   ioctl_dout,
  input  logic [7:0]   ioctl_index,
  input  logic [7:0]   rom_slot_base,
  output logic         ioctl_wait,
  output logic         mem_we,
  output logic [22:0]  mem_addr,
  output logic [1:0]   mem_bank,
  output logic [7:0]   mem_din,
  output logic [255:0] rom_map,
  output logic         cpu_reset,
  output logic         load_done,
  output logic         overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] WAIT_CNT = CW'(WAIT_LEVEL);

  typedef struct packed {
    logic [22:0] addr;
    logic [7:0]  data;
    logic        dual;
  } entry_t;

  typedef enum logic [1:0] {IDLE, WR0, WR1, COMMIT} state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           wait_q, wait_d;
  logic           overflow_q, overflow_d;
  logic           mem_we_q, mem_we_d;
  logic [22:0]    mem_addr_q, mem_addr_d;
  logic [1:0]     mem_bank_q, mem_bank_d;
  logic [7:0]     mem_din_q, mem_din_d;
  logic           dual_q, dual_d;
  logic [255:0]   rom_map_q, rom_map_d;
  logic           dl_q, dl_d;
  logic           active_q, active_d;
  logic           pending_q, pending_d;
  logic           cpu_reset_q, cpu_reset_d;
  logic           load_done_q, load_done_d;

  entry_t         fifo_mem [FIFO_DEPTH];
  entry_t         in_entry, head;
  logic           idx_ok, map_ok, dual_in, push_req, push, pop, full;
  logic [8:0]     page;
  logic [7:0]     slot_page;

  // Ingress: filter the byte and compute its SDRAM page.
  assign slot_page = rom_slot_base + ioctl_addr[21:14];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    idx_ok = (ioctl_index[4:0] < 5'd4);
    map_ok = 1'b0;
    page   = 9'h000;
    if (ioctl_index == 8'd0) begin
      case (ioctl_addr[24:14])
        11'd0:   begin map_ok = 1'b1; page = 9'h000; end
        11'd1:   begin map_ok = 1'b1; page = 9'h100; end
        11'd2:   begin map_ok = 1'b1; page = 9'h107; end
        11'd3:   begin map_ok = 1'b1; page = 9'h0FF; end
        default: begin map_ok = 1'b0; page = 9'h000; end
      endcase
    end else begin
      map_ok = 1'b1;
      page   = {1'b1, slot_page};
    end
    dual_in  = (ioctl_index[7:6] == 2'd1) | (ioctl_index[5:0] != 6'd0);
    in_entry = '{addr: {page, ioctl_addr[13:0]}, data: ioctl_dout, dual: dual_in};
    push_req = ioctl_download & ioctl_wr & idx_ok & map_ok;
    full     = (count_q == FULL_CNT);
    push     = push_req & ~full;
  end

  // NOTE: FIFO storage carries no reset; the pointers and count alone define validity.
  always_ff @(posedge clk_sys) begin
    if (push) fifo_mem[wr_ptr_q] <= in_entry;
  end

  assign head = fifo_mem[rd_ptr_q];

  // Write sequencer: pop, write bank 0 (and bank 1 when dual), then commit.
  always_comb begin
    state_d    = state_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_bank_d = mem_bank_q;
    mem_din_d  = mem_din_q;
    dual_d     = dual_q;
    rom_map_d  = rom_map_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop        = 1'b1;
          mem_addr_d = head.addr;
          mem_din_d  = head.data;
          dual_d     = head.dual;
          mem_bank_d = 2'd0;
          mem_we_d   = 1'b1;
          state_d    = WR0;
        end
      end
      WR0: begin
        if (ce_ref) begin
          if (dual_q) begin
            mem_bank_d = 2'd1;
            state_d    = WR1;
          end else begin
            mem_we_d = 1'b0;
            state_d  = COMMIT;
          end
        end
      end
      WR1: begin
        if (ce_ref) begin
          mem_we_d = 1'b0;
          state_d  = COMMIT;
        end
      end
      COMMIT: begin
        if (mem_addr_q[22]) rom_map_d[mem_addr_q[21:14]] = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO bookkeeping, backpressure and download/reset control.
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    wait_d      = (count_q >= WAIT_CNT);
    overflow_d  = overflow_q | (push_req & full);

    dl_d        = ioctl_download;
    active_d    = active_q;
    pending_d   = pending_q;
    cpu_reset_d = cpu_reset_q;
    load_done_d = 1'b0;
    if (ioctl_download && !dl_q && idx_ok) begin
      active_d    = 1'b1;
      pending_d   = 1'b0;
      cpu_reset_d = 1'b1;
    end else if (!ioctl_download && dl_q && active_q) begin
      active_d  = 1'b0;
      pending_d = 1'b1;
    end else if (pending_q && (count_q == '0) && (state_q == IDLE)) begin
      // Empty FIFO in IDLE means the last byte has passed COMMIT.
      pending_d   = 1'b0;
      cpu_reset_d = 1'b0;
      load_done_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wait_q      <= 1'b0;
      overflow_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_bank_q  <= '0;
      mem_din_q   <= '0;
      dual_q      <= 1'b0;
      rom_map_q   <= '0;
      dl_q        <= 1'b0;
      active_q    <= 1'b0;
      pending_q   <= 1'b0;
      cpu_reset_q <= 1'b1;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wait_q      <= wait_d;
      overflow_q  <= overflow_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_bank_q  <= mem_bank_d;
      mem_din_q   <= mem_din_d;
      dual_q      <= dual_d;
      rom_map_q   <= rom_map_d;
      dl_q        <= dl_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      cpu_reset_q <= cpu_reset_d;
      load_done_q <= load_done_d;
    end
  end

  assign ioctl_wait = wait_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_bank   = mem_bank_q;
  assign mem_din    = mem_din_q;
  assign rom_map    = rom_map_q;
  assign cpu_reset  = cpu_reset_q;
  assign load_done  = load_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_rom_boot_sequencer.sv
// Directed bench for rom_boot_sequencer: mapping, dual-bank writes, backpressure,
// overflow, cpu_reset/load_done sequencing and mid-write reset.
module tb_rom_boot_sequencer;

  logic         clk_sys = 1'b0;
  logic         reset_n;
  logic         ce_ref;
  logic         ioctl_download;
  logic         ioctl_wr;
  logic [24:0]  ioctl_addr;
  logic [7:0]   ioctl_dout;
  logic [7:0]   ioctl_index;
  logic [7:0]   rom_slot_base;
  logic         ioctl_wait;
  logic         mem_we;
  logic [22:0]  mem_addr;
  logic [1:0]   mem_bank;
  logic [7:0]   mem_din;
  logic [255:0] rom_map;
  logic         cpu_reset;
  logic         load_done;
  logic         overflow;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int ld_cnt = 0;
  int ce_period = 1;
  int ce_phase  = 0;
  logic [32:0] wq[$];
  int          ws[$];

  rom_boot_sequencer dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ce_ref         (ce_ref),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .rom_slot_base  (rom_slot_base),
    .ioctl_wait     (ioctl_wait),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_bank       (mem_bank),
    .mem_din        (mem_din),
    .rom_map        (rom_map),
    .cpu_reset      (cpu_reset),
    .load_done      (load_done),
    .overflow       (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  // A write is taken at the rising edge following a negedge where mem_we and ce_ref are high.
  always @(negedge clk_sys) begin
    cyc++;
    if (reset_n && mem_we && ce_ref) begin
      wq.push_back({mem_bank, mem_addr, mem_din});
      ws.push_back(cyc);
    end
    if (reset_n && load_done) ld_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task tick();
    @(posedge clk_sys);
    #1;
    if (ce_period <= 1) ce_ref = 1'b1;
    else begin
      ce_ref   = (ce_phase == 0);
      ce_phase = (ce_phase + 1) % ce_period;
    end
  endtask

  task send_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task apply_reset();
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    wq.delete();
    ws.delete();
  endtask

  task wait_writes(input int n, input int budget);
    for (int i = 0; i < budget && wq.size() < n; i++) tick();
    repeat (6) tick();
  endtask

  function automatic logic [32:0] wr_at(input int i);
    return (i < wq.size()) ? wq[i] : '1;
  endfunction

  logic [255:0] exp_map;
  logic         wait_after [6];
  int           ld0;

  initial begin
    reset_n        = 1'b0;
    ce_ref         = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    ioctl_index    = '0;
    rom_slot_base  = '0;
    #23;
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_bus", {mem_bank, mem_addr, mem_din}, 33'd0);
    check("rst_rom_map", rom_map, '0);
    check("rst_flags", {ioctl_wait, load_done, overflow}, 3'b000);
    check("rst_cpu_reset", cpu_reset, 1'b1);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // Base ROM: four segments, single bank, commit order preserved.
    ce_period      = 1;
    ioctl_index    = 8'h00;
    ioctl_download = 1'b1;
    ld0 = ld_cnt;
    tick();
    send_byte(25'h00000, 8'h11);
    send_byte(25'h04000, 8'h22);
    send_byte(25'h08000, 8'h33);
    send_byte(25'h0C000, 8'h44);
    ioctl_download = 1'b0;
    wait_writes(4, 100);
    check("t1_nwr", wq.size(), 4);
    check("t1_wr0", wr_at(0), {2'd0, 23'h000000, 8'h11});
    check("t1_wr1", wr_at(1), {2'd0, 23'h400000, 8'h22});
    check("t1_wr2", wr_at(2), {2'd0, 23'h41C000, 8'h33});
    check("t1_wr3", wr_at(3), {2'd0, 23'h3FC000, 8'h44});
    exp_map = '0;
    exp_map[8'h00] = 1'b1;
    exp_map[8'h07] = 1'b1;
    check("t1_rom_map", rom_map, exp_map);
    check("t1_overflow", overflow, 1'b0);
    check("t1_cpu_reset", cpu_reset, 1'b0);
    check("t1_load_done_cnt", ld_cnt - ld0, 1);

    // Out-of-range base ROM segment is dropped; empty download releases after one cycle.
    wq.delete();
    ws.delete();
    ld0 = ld_cnt;
    ioctl_download = 1'b1;
    tick();
    check("t2_cpu_reset_rise", cpu_reset, 1'b1);
    send_byte(25'h10005, 8'h5A);
    ioctl_download = 1'b0;
    tick();
    check("t2_cpu_reset_hold", cpu_reset, 1'b1);
    tick();
    check("t2_cpu_reset_fall", cpu_reset, 1'b0);
    check("t2_load_done", load_done, 1'b1);
    repeat (10) tick();
    check("t2_nwr", wq.size(), 0);
    check("t2_rom_map", rom_map, exp_map);
    check("t2_wait", ioctl_wait, 1'b0);
    check("t2_load_done_cnt", ld_cnt - ld0, 1);

    // Expansion ROM into both banks, one bank per ce_ref slot.
    apply_reset();
    ce_period      = 8;
    ce_phase       = 1;
    ioctl_index    = 8'h41;
    rom_slot_base  = 8'h07;
    ioctl_download = 1'b1;
    tick();
    send_byte(25'h00123, 8'hA5);
    ioctl_download = 1'b0;
    wait_writes(2, 100);
    check("t3_nwr", wq.size(), 2);
    check("t3_wr_bank0", wr_at(0), {2'd0, 23'h41C123, 8'hA5});
    check("t3_wr_bank1", wr_at(1), {2'd1, 23'h41C123, 8'hA5});
    check("t3_slot_gap", (ws.size() == 2) ? ws[1] - ws[0] : -1, 8);
    exp_map = '0;
    exp_map[8'h07] = 1'b1;
    check("t3_rom_map", rom_map, exp_map);
    check("t3_cpu_reset", cpu_reset, 1'b0);

    // Streaming source that honours ioctl_wait.
    wq.delete();
    ws.delete();
    ioctl_index    = 8'h80;
    rom_slot_base  = 8'h10;
    ce_phase       = 1;
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      for (int g = 0; g < 200 && ioctl_wait; g++) tick();
      send_byte(25'(i), 8'(8'h60 + i));
      wait_after[i] = ioctl_wait;
    end
    ioctl_download = 1'b0;
    wait_writes(6, 300);
    check("t4_wait_after_b4", wait_after[3], 1'b0);
    check("t4_wait_after_b5", wait_after[4], 1'b1);
    check("t4_overflow", overflow, 1'b0);
    check("t4_nwr", wq.size(), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("t4_wr%0d", i), wr_at(i), {2'd0, 23'h440000 + 23'(i), 8'(8'h60 + i)});

    // Same stream ignoring ioctl_wait: the head is already popped, so b2..b5 fill
    // the FIFO and b6 is the dropped byte.
    wq.delete();
    ws.delete();
    ce_phase       = 1;
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) send_byte(25'(i), 8'(8'h70 + i));
    ioctl_download = 1'b0;
    wait_writes(6, 120);
    check("t5_overflow", overflow, 1'b1);
    check("t5_nwr", wq.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("t5_wr%0d", i), wr_at(i), {2'd0, 23'h440000 + 23'(i), 8'(8'h70 + i)});

    // Download ends with two entries pending.
    apply_reset();
    check("t6_overflow_cleared", overflow, 1'b0);
    ce_period      = 8;
    ce_phase       = 1;
    ioctl_index    = 8'h80;
    rom_slot_base  = 8'h20;
    ioctl_download = 1'b1;
    tick();
    send_byte(25'h00000, 8'hC1);
    send_byte(25'h00001, 8'hC2);
    ioctl_download = 1'b0;
    ld0 = ld_cnt;
    repeat (3) tick();
    check("t6_hold_cpu_reset", cpu_reset, 1'b1);
    check("t6_hold_nwr", wq.size(), 0);
    for (int g = 0; g < 200 && cpu_reset; g++) tick();
    check("t6_fall_nwr", wq.size(), 2);
    check("t6_fall_load_done", load_done, 1'b1);
    exp_map = '0;
    exp_map[8'h20] = 1'b1;
    check("t6_rom_map", rom_map, exp_map);
    check("t6_wr0", wr_at(0), {2'd0, 23'h480000, 8'hC1});
    check("t6_wr1", wr_at(1), {2'd0, 23'h480001, 8'hC2});
    repeat (5) tick();
    check("t6_load_done_cnt", ld_cnt - ld0, 1);

    // reset_n asserted while the bank-1 write is pending.
    wq.delete();
    ws.delete();
    ce_phase       = 1;
    ioctl_index    = 8'h41;
    rom_slot_base  = 8'h07;
    ioctl_download = 1'b1;
    tick();
    send_byte(25'h00123, 8'hA5);
    for (int g = 0; g < 100 && !(mem_we && mem_bank == 2'd1); g++) tick();
    check("t7_in_wr1", {mem_we, mem_bank}, 3'b101);
    reset_n = 1'b0;
    #1;
    check("t7_abort_mem_we", mem_we, 1'b0);
    check("t7_abort_cpu_reset", cpu_reset, 1'b1);
    check("t7_abort_bank", mem_bank, 2'd0);
    check("t7_abort_nwr", wq.size(), 1);
    ioctl_download = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (20) tick();
    check("t7_no_more_writes", wq.size(), 1);
    check("t7_mem_we_idle", mem_we, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
